sel_step_ctrl: RTL and testbench
================================

SEL_STEP_CTRL -- requirements
Module: sel_step_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning the consecutive stable cycles a button must hold before it is accepted (legal range 2..65535).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, meaning the clock cycles per automatic select step (legal range 2..2^20).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_up, input, 1 bit: raw, asynchronous, bouncing "next" button, active-high.
REQ-006 SHALL have port btn_dn, input, 1 bit: raw, asynchronous, bouncing "previous" button, active-high.
REQ-007 SHALL have port auto_en, input, 1 bit, synchronous to clk: 1 enables automatic stepping.
REQ-008 SHALL have port sel, output, 2 bits: registered select, driven to the sel input of the downstream 4:1 mux.
REQ-009 SHALL have port sel_chg, output, 1 bit: one-cycle pulse in the first cycle a new sel value is visible.

Function
REQ-010 SHALL pass btn_up and btn_dn each through a 2-flop synchronizer before any other logic; the synchronizer output is called s_up or s_dn.
REQ-011 SHALL give each button an independent debounce FSM with states IDLE, PRESS_CHK, HELD and REL_CHK.
REQ-012 IDLE: SHALL move to PRESS_CHK and clear the counter when s_x=1.
REQ-013 PRESS_CHK: SHALL return to IDLE if s_x=0, otherwise increment the counter; when the counter reaches DEB_CYCLES-1 with s_x=1, it SHALL move to HELD and raise an internal accept pulse for exactly one cycle.
REQ-014 HELD: SHALL move to REL_CHK and clear the counter when s_x=0; holding the button SHALL produce no further accepts (no auto-repeat).
REQ-015 REL_CHK: SHALL return to HELD if s_x=1, otherwise count; after DEB_CYCLES consecutive cycles with s_x=0 it SHALL move to IDLE.
REQ-016 Latency: a clean press SHALL change sel exactly 2 (sync) + DEB_CYCLES + 1 cycles after btn_x rises.
REQ-017 An up accept SHALL set sel <= sel+1 mod 4 (3 wraps to 0); a down accept SHALL set sel <= sel-1 mod 4 (0 wraps to 3).
REQ-018 Up and down accepts in the same cycle SHALL cancel: sel is unchanged and sel_chg stays 0.
REQ-019 The prescaler SHALL count 0..SCAN_DIV-1 while auto_en=1 and raise an auto tick when it wraps from SCAN_DIV-1 to 0; an auto tick SHALL increment sel mod 4.
REQ-020 auto_en=0 SHALL hold the prescaler at 0; re-enabling SHALL give the first tick SCAN_DIV cycles later.
REQ-021 Any manual accept SHALL take priority over an auto tick in the same cycle, and SHALL also clear the prescaler to 0.
REQ-022 When an up and a down accept cancel each other (REQ-018), the prescaler SHALL still be cleared and the auto tick SHALL be suppressed.
REQ-023 sel_chg SHALL be 1 in the cycle after any sel register update, and 0 otherwise.
REQ-024 sel SHALL come straight from a flop, with no combinational path from any input.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock, force sel=0, sel_chg=0, both FSMs to IDLE, all counters to 0 and the synchronizer flops to 0.
REQ-026 Reset asserted mid-debounce or mid-scan SHALL discard the pending accept or tick; no sel_chg pulse SHALL follow deassertion.
REQ-027 A button already held when rst_n deasserts SHALL go through the full PRESS_CHK sequence, and SHALL then produce exactly one accept.

Verification
REQ-028 DEB_CYCLES=4: reset, then hold btn_up high -> sel goes 0->1 exactly 7 cycles after the rise, sel_chg pulses once, and there is no further change while held.
REQ-029 Bounce: btn_up toggles every 2 cycles for 20 cycles, then is released -> sel stays 0 and sel_chg never asserts.
REQ-030 Wrap: sel=0, one clean btn_dn press -> sel=3; then four clean btn_up presses -> sel sequence 0,1,2,3.
REQ-031 Both buttons pressed in the same cycle and held -> sel unchanged, sel_chg=0, prescaler cleared.
REQ-032 SCAN_DIV=8, auto_en=1 -> sel steps every 8 cycles: 1,2,3,0; an up accept in the same cycle as a tick -> only +1, and the next tick comes 8 cycles later.
REQ-033 rst_n pulsed low for less than one clock period while in PRESS_CHK with sel=2 -> sel=0 with no clock edge, FSM in IDLE, and no pulse after release.

Source files
------------

// File: rtl/sel_step_ctrl.sv
// sel_step_ctrl -- select generator for a downstream 4:1 mux.
//
// Two raw, bouncing push buttons (next / previous) are synchronised and
// debounced. Each accepted press steps a 2-bit select up or down (mod 4).
// An optional prescaler steps the select automatically every SCAN_DIV
// cycles while auto_en is high. Manual presses take priority and restart
// the prescaler.
//
// Parameters
//   DEB_CYCLES : consecutive stable cycles before a press/release is taken (2..65535)
//   SCAN_DIV   : clock cycles per automatic step (2..2^20)
//
// Ports
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   btn_up  : raw "next" button, active-high, asynchronous
//   btn_dn  : raw "previous" button, active-high, asynchronous
//   auto_en : synchronous enable for automatic stepping
//   sel     : registered select output
//   sel_chg : one-cycle pulse in the first cycle a new sel is visible

// Debounce FSM for one synchronised button. accept pulses for one cycle in
// the cycle the press is confirmed; holding the button never re-accepts.
module sel_step_deb #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_in,
  output logic accept
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_t;

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (s_in) begin
          state_nx = PRESS_CHK;
          cnt_nx   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s_in) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = HELD;
          accept   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s_in) begin
          state_nx = REL_CHK;
          cnt_nx   = '0;
        end
      end
      REL_CHK: begin
        if (s_in) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

module sel_step_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       auto_en,
  output logic [1:0] sel,
  output logic       sel_chg
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);

  logic          up_s1, s_up;
  logic          dn_s1, s_dn;
  logic          acc_up, acc_dn;
  logic [PW-1:0] psc, psc_nx;
  logic          tick;
  logic [1:0]    sel_nx;
  logic          upd;

  // Two-flop synchronisers for the raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_s1 <= 1'b0;
      s_up  <= 1'b0;
      dn_s1 <= 1'b0;
      s_dn  <= 1'b0;
    end else begin
      up_s1 <= btn_up;
      s_up  <= up_s1;
      dn_s1 <= btn_dn;
      s_dn  <= dn_s1;
    end
  end

  sel_step_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_in   (s_up),
    .accept (acc_up)
  );

  sel_step_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_in   (s_dn),
    .accept (acc_dn)
  );

  // Any manual accept, including an up/down pair that cancels, restarts the
  // prescaler and swallows a coincident auto tick.
  always_comb begin
    tick   = 1'b0;
    psc_nx = '0;
    if (!(acc_up || acc_dn) && auto_en) begin
      if (psc == PSC_LAST) begin
        tick = 1'b1;
      end else begin
        psc_nx = psc + 1'b1;
      end
    end

    sel_nx = sel;
    upd    = 1'b0;
    if (acc_up && !acc_dn) begin
      sel_nx = sel + 2'd1;
      upd    = 1'b1;
    end else if (acc_dn && !acc_up) begin
      sel_nx = sel - 2'd1;
      upd    = 1'b1;
    end else if (tick) begin
      sel_nx = sel + 2'd1;
      upd    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc     <= '0;
      sel     <= '0;
      sel_chg <= 1'b0;
    end else begin
      psc     <= psc_nx;
      sel     <= sel_nx;
      sel_chg <= upd;
    end
  end

endmodule

// File: tb/tb_sel_step_ctrl.sv
module tb_sel_step_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned SD  = 8;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       btn_up  = 1'b0;
  logic       btn_dn  = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] sel;
  logic       sel_chg;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  sel_step_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .auto_en (auto_en),
    .sel     (sel),
    .sel_chg (sel_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a button press is accepted when, from the released
  // condition, the synchronised level has been high for DEB+1 consecutive
  // samples; the released condition returns after DEB+1 consecutive low
  // samples. Synchronised level = raw input two clocks earlier.
  bit m_p1[2]    = '{0, 0};
  bit m_p2[2]    = '{0, 0};
  bit m_armed[2] = '{1, 1};
  int m_hi[2]    = '{0, 0};
  int m_lo[2]    = '{0, 0};
  int m_since    = 0;
  int m_sel      = 0;
  bit m_chg      = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = '{0, 0}; m_p2 = '{0, 0}; m_armed = '{1, 1};
      m_hi = '{0, 0}; m_lo = '{0, 0};
      m_since = 0; m_sel = 0; m_chg = 0;
    end else begin
      bit raw[2];
      bit acc[2];
      bit lvl;
      bit tick;
      raw[0] = btn_up;
      raw[1] = btn_dn;
      for (int b = 0; b < 2; b++) begin
        lvl     = m_p2[b];
        m_p2[b] = m_p1[b];
        m_p1[b] = raw[b];
        if (lvl) begin m_hi[b]++; m_lo[b] = 0; end
        else     begin m_lo[b]++; m_hi[b] = 0; end
        acc[b] = 0;
        if (m_armed[b] && m_hi[b] == DEB + 1) begin
          acc[b] = 1; m_armed[b] = 0;
        end else if (!m_armed[b] && m_lo[b] == DEB + 1) begin
          m_armed[b] = 1;
        end
      end
      tick = 0;
      if (acc[0] || acc[1] || !auto_en) begin
        m_since = 0;
      end else begin
        m_since++;
        if (m_since == SD) begin tick = 1; m_since = 0; end
      end
      m_chg = 0;
      if (acc[0] && !acc[1])      begin m_sel = (m_sel + 1) % 4; m_chg = 1; end
      else if (acc[1] && !acc[0]) begin m_sel = (m_sel + 3) % 4; m_chg = 1; end
      else if (tick)              begin m_sel = (m_sel + 1) % 4; m_chg = 1; end
    end
  end

  // Lock-step comparison against the model, every cycle.
  always @(negedge clk) begin
    chk("sel", 32'(sel), 32'(m_sel));
    chk("sel_chg", 32'(sel_chg), 32'(m_chg));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; auto_en = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_chg", 32'(sel_chg), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_pulses(input int unsigned n, output int unsigned p);
    p = 0;
    repeat (n) begin
      @(negedge clk);
      if (sel_chg === 1'b1) p++;
    end
  endtask

  // Edges until the next sel_chg, 0 if none within limit.
  task automatic wait_chg(input int unsigned limit, output int unsigned lat);
    lat = 0;
    for (int k = 1; k <= int'(limit); k++) begin
      @(posedge clk);
      #1;
      if (sel_chg === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic press(input bit up, input int unsigned hold, input int unsigned gap);
    @(negedge clk);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned lat, p;
    int unsigned run_left[2];

    // Clean held press: latency, single pulse, no auto-repeat.
    do_reset();
    @(negedge clk);
    btn_up = 1'b1;
    wait_chg(30, lat);
    chk("press_latency", lat, DEB + 3);
    chk("press_sel", 32'(sel), 1);
    @(posedge clk);
    count_pulses(20, p);
    chk("held_pulses", p, 0);
    chk("held_sel", 32'(sel), 1);
    btn_up = 1'b0;
    repeat (15) @(negedge clk);

    // Bounce shorter than the debounce window.
    do_reset();
    p = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 2 == 0) btn_up = ~btn_up;
      if (sel_chg === 1'b1) p++;
    end
    btn_up = 1'b0;
    count_pulses(20, lat);
    chk("bounce_pulses", p + lat, 0);
    chk("bounce_sel", 32'(sel), 0);

    // Wrap both ways.
    press(1'b0, 10, 14);
    chk("wrap_dn_sel", 32'(sel), 3);
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 10, 14);
      chk("wrap_up_sel", 32'(sel), 32'(i));
    end

    // Simultaneous presses cancel.
    @(negedge clk);
    btn_up = 1'b1; btn_dn = 1'b1;
    count_pulses(20, p);
    chk("both_pulses", p, 0);
    chk("both_sel", 32'(sel), 3);
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (14) @(negedge clk);

    // Cancelled pair still restarts the prescaler: the tick due at edge SD is
    // swallowed by the accept at DEB+3 and the next one lands SD later.
    @(negedge clk);
    auto_en = 1'b1; btn_up = 1'b1; btn_dn = 1'b1;
    wait_chg(40, lat);
    chk("cancel_tick_lat", lat, DEB + 3 + SD);
    chk("cancel_tick_sel", 32'(sel), 0);
    @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0; auto_en = 1'b0;
    repeat (14) @(negedge clk);

    // Automatic stepping and collision of an up accept with a tick.
    do_reset();
    @(negedge clk);
    auto_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_chg(20, lat);
      chk("auto_period", lat, SD);
      chk("auto_sel", 32'(sel), 32'(i % 4));
    end
    @(negedge clk);
    @(negedge clk);
    btn_up = 1'b1;
    wait_chg(20, lat);
    chk("collide_lat", lat, DEB + 3);
    chk("collide_sel", 32'(sel), 1);
    wait_chg(20, lat);
    chk("after_collide_period", lat, SD);
    chk("after_collide_sel", 32'(sel), 2);
    @(negedge clk);
    btn_up = 1'b0; auto_en = 1'b0;
    repeat (14) @(negedge clk);

    // Short reset pulse while a press is being qualified.
    do_reset();
    press(1'b1, 10, 14);
    press(1'b1, 10, 14);
    chk("pre_glitch_sel", 32'(sel), 2);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0; btn_up = 1'b0;
    #1;
    chk("glitch_sel", 32'(sel), 0);
    chk("glitch_chg", 32'(sel_chg), 0);
    #1;
    rst_n = 1'b1;
    count_pulses(20, p);
    chk("glitch_after_pulses", p, 0);
    chk("glitch_after_sel", 32'(sel), 0);

    // Button held through reset gives exactly one accept.
    @(negedge clk);
    rst_n = 1'b0; btn_up = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(30, p);
    chk("held_reset_pulses", p, 1);
    chk("held_reset_sel", 32'(sel), 1);
    btn_up = 1'b0;
    repeat (14) @(negedge clk);

    // Random runs of button levels, auto_en flips and short reset pulses.
    run_left[0] = 0;
    run_left[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
        if (run_left[b] == 0) begin
          run_left[b] = $urandom_range(1, 12);
          if (b == 0) btn_up = 1'($urandom_range(0, 1));
          else        btn_dn = 1'($urandom_range(0, 1));
        end
        run_left[b]--;
      end
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
